scg_burst_seq: RTL
==================

# scg_burst_seq

Parametrised burst command-sequence generator for the SDRAM controller. It issues the column command and frames the data beats for one burst: a write or read, with or without auto-precharge, of configurable length. It then waits out a recovery period and reports completion. It sits between the controller's main FSM, which owns the `start`/`done` handshake, and the command/data-path muxes, which consume `command`, `chip` and `beat`.

## Interface
Parameters:
- `BURST_LEN`, 4: data beats per burst; legal values 1, 2, 4, 8.
- `CAS_LAT`, 2: read latency, counted in cycles from the READ command to the first data beat; legal range 1..3.
- `REC_CYC`, 1: recovery cycles after the last beat (tWR or tRP budget); legal range 0..7.

Ports:
- `clk`, input, 1: clock.
- `n_rst`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: level request; held high until `done` is seen.
- `rw`, input, 1: 0 = write, 1 = read; sampled when `start` is accepted.
- `ap`, input, 1: 1 = auto-precharge variant; sampled when `start` is accepted.
- `done`, output, 1: high in the DONE state.
- `busy`, output, 1: high in any state other than IDLE or DONE.
- `chip`, output, 1: data-beat strobe (data bus enable), high in the DATA state only.
- `command`, output, 4: SDRAM command code; NOP whenever no command is issued.
- `beat`, output, $clog2(BURST_LEN) (minimum width 1): index of the current beat while in DATA; 0 otherwise.

## Operation
- Command codes: `CMD_NOP`=0, `CMD_WRITE`=3, `CMD_WRITEAP`=4, `CMD_READ`=5, `CMD_READAP`=6.
- States: IDLE, CMD, LAT, DATA, RECOV, DONE.
- IDLE:
  - Stays in IDLE while `start`=0.
  - On `start`=1, latches `rw` and `ap`.
  - A write goes to DATA; a read goes to CMD.
- CMD (reads only):
  - Lasts one cycle and drives `CMD_READ` or `CMD_READAP`.
  - Next state is LAT if `CAS_LAT`>1, otherwise DATA.
- LAT: lasts `CAS_LAT`-1 cycles with `command`=NOP, then goes to DATA.
- DATA:
  - Lasts `BURST_LEN` cycles; `chip`=1 and `beat` counts 0..`BURST_LEN`-1.
  - For a write, `CMD_WRITE` or `CMD_WRITEAP` is driven on beat 0 only, since the command travels with the first data word. All other beats drive NOP.
  - Next state is RECOV if `REC_CYC`>0, otherwise DONE.
- RECOV: lasts `REC_CYC` cycles with NOP and `chip`=0, then goes to DONE.
- DONE: `done`=1; the FSM returns to IDLE on the first cycle with `start`=0. There is no re-trigger without passing through IDLE.
- `start` falling mid-burst is ignored; the burst always completes. `rw` and `ap` changing mid-burst are ignored.
- A single shared down-counter times LAT, DATA and RECOV. `beat` is `BURST_LEN`-1 minus the counter value during DATA.
- Reset in any state forces IDLE immediately. All outputs go to 0 and `command` goes to NOP.

## Timing
- All outputs are registered-state decodes (Moore); there is no combinational path from inputs to outputs.
- Reset values: `done`=0, `busy`=0, `chip`=0, `command`=0, `beat`=0.
- Cycle 0 is defined as the edge that samples `start`=1.
- Write latency: `chip` is high in cycles 1..BL. `done` first rises in cycle BL+REC+1 (cycle 6 for the defaults).
- Read latency: CMD occupies cycle 1 and data occupies cycles CL+1..CL+BL. `done` first rises in cycle CL+BL+REC+1 (cycle 8 for the defaults).
- `done` falls one cycle after the cycle in which `start` is sampled 0. The earliest re-acceptance of `start` is the cycle after that.

## Configuration
- The macro `SCG_BRST_READ_EN` gates read support.
- Defined: the read path is compiled in (CMD and LAT states and the READ/READAP codes).
- Undefined: CMD and LAT are not compiled in, and `rw` is ignored and treated as 0. Every request is a write; the write timing is unchanged.

## Structure
- The package `scg_pkg` holds the command-code constants (`CMD_*`) and the state enum typedef. It is shared with the other scg_* sequencers.
- The sub-module `scg_cycle_cnt` is a loadable down-counter with a zero flag. Its width is set by a parameter equal to $clog2 of the largest of `BURST_LEN`, `CAS_LAT` and `REC_CYC`, plus 1.

## Test plan
- Default write, `ap`=1:
  - `chip` is high in cycles 1–4, with `command`=4 in cycle 1 only.
  - `done` rises in cycle 6 and holds until `start` drops, then clears on the next cycle.
- Default read, `ap`=0:
  - `command`=5 in cycle 1.
  - `chip` is high in cycles 3–6 with `beat` 0,1,2,3.
  - `done` rises in cycle 8.
- Corner parameters `BURST_LEN`=1, `CAS_LAT`=1, `REC_CYC`=0, read:
  - CMD in cycle 1, a single beat in cycle 2, `done` in cycle 3.
  - No LAT or RECOV states are entered.
- `start` dropped in cycle 2 of a write and `rw` toggled mid-burst:
  - The burst completes unchanged.
  - `done` pulses for one cycle, then the FSM returns to IDLE.
- `n_rst` asserted during DATA beat 2: all outputs are 0 immediately, the FSM is in IDLE, and a new `start` begins a clean burst.
- Build without `SCG_BRST_READ_EN` and request with `rw`=1: write timing is produced, with `command`=3 on beat 0.

Source files
------------

// File: rtl/scg_pkg.sv
// Shared definitions for the scg_* command sequencers.
// This file holds the SDRAM command codes, the sequencer state encoding and a sizing helper.
package scg_pkg;

    // SDRAM command codes driven onto the command mux
    localparam logic [3:0] CMD_NOP     = 4'd0;
    localparam logic [3:0] CMD_WRITE   = 4'd3;
    localparam logic [3:0] CMD_WRITEAP = 4'd4;
    localparam logic [3:0] CMD_READ    = 4'd5;
    localparam logic [3:0] CMD_READAP  = 4'd6;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCmd   = 3'd1,
        StLat   = 3'd2,
        StData  = 3'd3,
        StRecov = 3'd4,
        StDone  = 3'd5
    } scg_state_e;

    // Largest of three cycle budgets; sizes the shared timing counter
    function automatic int unsigned scg_max3(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/scg_cycle_cnt.sv
// Loadable down-counter with a zero flag.
// It times the latency, data and recovery phases of a burst.
// It saturates at zero, and a load always wins over counting.
module scg_cycle_cnt #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Next count: load, else decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/scg_burst_seq.sv
// Burst command-sequence generator for the SDRAM controller.
// It issues the column command, frames BURST_LEN data beats, waits out recovery and then
// holds done until start drops.
// The macro SCG_BRST_READ_EN compiles in the read path (the CMD and LAT states).
// Without it, every request is a write.
module scg_burst_seq
    import scg_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CAS_LAT   = 2,
    parameter int unsigned REC_CYC   = 1,
    localparam int unsigned BeatW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             rw,
    input  logic             ap,
    output logic             done,
    output logic             busy,
    output logic             chip,
    output logic [3:0]       command,
    output logic [BeatW-1:0] beat
);

    localparam int unsigned MaxCyc = scg_max3(BURST_LEN, CAS_LAT, REC_CYC);
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    scg_state_e      state_q, state_d;
    logic            ap_q, ap_d;
    logic            is_read;
    logic            cnt_load;
    logic [CntW-1:0] cnt_val;
    logic [CntW-1:0] cnt;
    logic            cnt_zero;

`ifdef SCG_BRST_READ_EN
    logic rw_q, rw_d;
    assign is_read = rw_q;
`else
    logic unused_rw;
    assign unused_rw = rw;
    assign is_read   = 1'b0;
`endif

    scg_cycle_cnt #(
        .WIDTH(CntW)
    ) u_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .cnt     (cnt),
        .zero    (cnt_zero)
    );

    // Next-state logic; each timed phase loads the counter with its length minus one
    always_comb begin
        state_d  = state_q;
        ap_d     = ap_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
`ifdef SCG_BRST_READ_EN
        rw_d     = rw_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ap_d = ap;
`ifdef SCG_BRST_READ_EN
                    rw_d = rw;
                    if (rw) begin
                        state_d = StCmd;
                    end else begin
                        state_d  = StData;
                        cnt_load = 1'b1;
                        cnt_val  = CntW'(BURST_LEN - 1);
                    end
`else
                    state_d  = StData;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(BURST_LEN - 1);
`endif
                end
            end
`ifdef SCG_BRST_READ_EN
            StCmd: begin
                cnt_load = 1'b1;
                if (CAS_LAT > 1) begin
                    state_d = StLat;
                    cnt_val = CntW'(CAS_LAT - 2);
                end else begin
                    state_d = StData;
                    cnt_val = CntW'(BURST_LEN - 1);
                end
            end
            StLat: begin
                if (cnt_zero) begin
                    state_d  = StData;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(BURST_LEN - 1);
                end
            end
`endif
            StData: begin
                if (cnt_zero) begin
                    if (REC_CYC > 0) begin
                        state_d  = StRecov;
                        cnt_load = 1'b1;
                        cnt_val  = CntW'(REC_CYC - 1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRecov: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and request registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            ap_q    <= 1'b0;
`ifdef SCG_BRST_READ_EN
            rw_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ap_q    <= ap_d;
`ifdef SCG_BRST_READ_EN
            rw_q    <= rw_d;
`endif
        end
    end

    // Moore output decode; beat 0 is the cycle the counter still holds BURST_LEN-1
    always_comb begin
        done    = (state_q == StDone);
        busy    = (state_q != StIdle) && (state_q != StDone);
        chip    = (state_q == StData);
        beat    = chip ? BeatW'(CntW'(BURST_LEN - 1) - cnt) : '0;
        command = CMD_NOP;
        if (state_q == StCmd) begin
            command = ap_q ? CMD_READAP : CMD_READ;
        end else if (chip && !is_read && (cnt == CntW'(BURST_LEN - 1))) begin
            command = ap_q ? CMD_WRITEAP : CMD_WRITE;
        end
    end

endmodule
